// File: rtl/mem_line_arbiter_if.sv
// Line-wide request/response bundle shared by the two requester ports and the memory side.
// A master drives the request fields; a slave returns the read line and completion.
interface mem_line_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input ready);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output rdata, output ready);
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter/sequencer giving two refill ports one line transaction at a time.
// Optional performance counters are built when MEM_LINE_ARB_PERF_EN is defined.
module mem_line_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_line_arbiter_if.slave  p0,
  mem_line_arbiter_if.slave  p1,
  mem_line_arbiter_if.master mem,
  output logic               busy
`ifdef MEM_LINE_ARB_PERF_EN
  ,
  output logic [31:0]        perf_p0_grants,
  output logic [31:0]        perf_p1_grants,
  output logic [31:0]        perf_conflicts,
  output logic [31:0]        perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  take;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  done;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p0.req || p1.req) begin
          state_d = StIssue;
          take    = 1'b1;
          // grant_q doubles as last_grant: on a conflict the other port wins
          grant_d = (p0.req && p1.req) ? ~grant_q : p1.req;
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (mem.ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (take) begin
        we_q    <= grant_d ? p1.we    : p0.we;
        addr_q  <= grant_d ? p1.addr  : p0.addr;
        wdata_q <= grant_d ? p1.wdata : p0.wdata;
      end
    end
  end

  // A completion arriving in the reset cycle must not reach the requester
  assign done = ~rst && (state_q == StWait) && mem.ready;

  always_comb begin
    mem.req   = (state_q == StIssue);
    mem.we    = we_q;
    mem.addr  = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    mem.wdata = wdata_q;
    busy      = (state_q != StIdle);
    p0.ready  = done && !grant_q;
    p1.ready  = done && grant_q;
    p0.rdata  = grant_q ? '0 : mem.rdata;
    p1.rdata  = grant_q ? mem.rdata : '0;
  end

`ifdef MEM_LINE_ARB_PERF_EN
  logic p0_waiting, p1_waiting;

  assign p0_waiting = p0.req && !(busy && !grant_q);
  assign p1_waiting = p1.req && !(busy && grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_p0_grants   <= '0;
      perf_p1_grants   <= '0;
      perf_conflicts   <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (take && !grant_d)      perf_p0_grants <= perf_p0_grants + 32'd1;
      if (take && grant_d)       perf_p1_grants <= perf_p1_grants + 32'd1;
      if (take && p0.req && p1.req) perf_conflicts <= perf_conflicts + 32'd1;
      if (p0_waiting || p1_waiting) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a one-cycle-latency line memory model.
// Perf-counter checks are compiled in when MEM_LINE_ARB_PERF_EN is defined.
module tb_mem_line_arbiter;

  localparam logic [127:0] LineA = 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF;
  localparam logic [127:0] LineW = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic stray = 1'b0;
  logic ready_q = 1'b0;
  logic [127:0] rdata_q = '0;
  logic [127:0] arr [256];
  int n_checks = 0;
  int n_bad = 0;

  mem_line_arbiter_if p0_if ();
  mem_line_arbiter_if p1_if ();
  mem_line_arbiter_if mem_if ();

`ifdef MEM_LINE_ARB_PERF_EN
  logic [31:0] perf_p0_grants, perf_p1_grants, perf_conflicts, perf_wait_cycles;
`endif

  mem_line_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .p0   (p0_if.slave),
    .p1   (p1_if.slave),
    .mem  (mem_if.master),
    .busy (busy)
`ifdef MEM_LINE_ARB_PERF_EN
    ,
    .perf_p0_grants   (perf_p0_grants),
    .perf_p1_grants   (perf_p1_grants),
    .perf_conflicts   (perf_conflicts),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Memory: samples mem_req, answers with ready and registered read data next cycle
  always @(posedge clk) begin
    if (rst) begin
      arr[8'h01] <= LineA;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= mem_if.req;
      if (mem_if.req) begin
        if (mem_if.we) arr[mem_if.addr[11:4]] <= mem_if.wdata;
        else           rdata_q <= arr[mem_if.addr[11:4]];
      end
    end
  end

  assign mem_if.ready = ready_q | stray;
  assign mem_if.rdata = rdata_q;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [127:0] wd);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wd;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wd;
    end
  endtask

  // One transaction on a single port; expects ready exactly in the third cycle
  task automatic do_xact(input int port, input logic we, input logic [31:0] addr,
                         input logic [127:0] wd, input logic [127:0] exp, input bit chk_rd);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    set_port(port, 1'b1, we, addr, wd);
    while (!got && cyc < 10) begin
      @(negedge clk);
      if (mem_if.req) begin
        check("xact_addr", mem_if.addr, addr & 32'hFFFF_FFF0);
        check("xact_we", mem_if.we, we);
      end
      if (p0_if.ready || p1_if.ready) begin
        got = 1'b1;
        check("xact_port", p1_if.ready, port[0]);
        if (chk_rd) check("xact_rdata", port == 0 ? p0_if.rdata : p1_if.rdata, exp);
      end
      cyc++;
      step();
    end
    set_port(port, 1'b0, 1'b0, 32'h0, 128'h0);
    check("xact_got_ready", got, 1'b1);
    check("xact_latency", cyc, 3);
  endtask

  int order [8];
  int n_iss;
  int n_rdy;
  int cyc;
  bit prev_req;

  initial begin
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 128'h0);

    // Reset values
    step();
    @(negedge clk);
    check("rst_mem_req", mem_if.req, 1'b0);
    check("rst_mem_we", mem_if.we, 1'b0);
    check("rst_mem_addr", mem_if.addr, 32'h0);
    check("rst_mem_wdata", mem_if.wdata, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", {p0_if.ready, p1_if.ready}, 2'b00);
    step();
    rst = 1'b0;

    // Single read with cycle-by-cycle timing
    set_port(0, 1'b1, 1'b0, 32'h0001_0013, 128'h0);
    @(negedge clk);
    check("rd_c0_mem_req", mem_if.req, 1'b0);
    step();
    @(negedge clk);
    check("rd_c1_mem_req", mem_if.req, 1'b1);
    check("rd_c1_addr", mem_if.addr, 32'h0001_0010);
    check("rd_c1_busy", busy, 1'b1);
    step();
    @(negedge clk);
    check("rd_c2_ready", p0_if.ready, 1'b1);
    check("rd_c2_rdata", p0_if.rdata, LineA);
    check("rd_c2_p1_rdata", p1_if.rdata, 128'h0);
    check("rd_c2_mem_req", mem_if.req, 1'b0);
    step();
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    @(negedge clk);
    check("rd_c3_busy", busy, 1'b0);
    check("rd_c3_ready", p0_if.ready, 1'b0);
    step();

    // Write then read on port 1
    do_xact(1, 1'b1, 32'h0001_0020, LineW, 128'h0, 1'b0);
    do_xact(1, 1'b0, 32'h0001_0020, 128'h0, LineW, 1'b1);

    // Round-robin under continuous conflict, from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h0000_0100, 128'h0);
    set_port(1, 1'b1, 1'b0, 32'h0000_0200, 128'h0);
    n_iss = 0;
    n_rdy = 0;
    cyc = 0;
    prev_req = 1'b0;
    while (n_rdy < 4 && cyc < 40) begin
      @(negedge clk);
      if (mem_if.req) begin
        check("rr_no_b2b", prev_req, 1'b0);
        if (n_iss < 8) order[n_iss] = (mem_if.addr == 32'h0000_0200) ? 1 : 0;
        n_iss++;
      end
      prev_req = mem_if.req;
      if (p0_if.ready || p1_if.ready) begin
        check("rr_one_ready", p0_if.ready && p1_if.ready, 1'b0);
        if (n_rdy < 8) check("rr_ready_port", p1_if.ready, order[n_rdy][0]);
        n_rdy++;
      end
      cyc++;
      step();
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 128'h0);
    check("rr_ready_count", n_rdy, 4);
    check("rr_issue_count", n_iss, 4);
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 0);
    check("rr_order3", order[3], 1);
`ifdef MEM_LINE_ARB_PERF_EN
    check("perf_p0_grants", perf_p0_grants, 32'd2);
    check("perf_p1_grants", perf_p1_grants, 32'd2);
    check("perf_conflicts_ge3", perf_conflicts >= 32'd3, 1'b1);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_quiet_mem_req", mem_if.req, 1'b0);
      step();
    end

    // Stray mem_ready in IDLE, then in ISSUE
    stray = 1'b1;
    @(negedge clk);
    check("stray_idle_ready", {p0_if.ready, p1_if.ready}, 2'b00);
    check("stray_idle_busy", busy, 1'b0);
    step();
    stray = 1'b0;
    @(negedge clk);
    check("stray_idle_after", busy, 1'b0);
    set_port(0, 1'b1, 1'b0, 32'h0001_0010, 128'h0);
    step();
    stray = 1'b1;
    @(negedge clk);
    check("stray_issue_mem_req", mem_if.req, 1'b1);
    check("stray_issue_ready", {p0_if.ready, p1_if.ready}, 2'b00);
    step();
    stray = 1'b0;
    @(negedge clk);
    check("stray_wait_busy", busy, 1'b1);
    check("stray_wait_ready", p0_if.ready, 1'b1);
    check("stray_wait_rdata", p0_if.rdata, LineA);
    step();
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    @(negedge clk);
    check("stray_done_busy", busy, 1'b0);

    // Reset in WAIT while the memory completes; last grant was port 0
    set_port(0, 1'b1, 1'b0, 32'h0000_0300, 128'h0);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rstw_busy_before", busy, 1'b1);
    check("rstw_mem_ready", mem_if.ready, 1'b1);
    check("rstw_no_ready", {p0_if.ready, p1_if.ready}, 2'b00);
    step();
    rst = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    @(negedge clk);
    check("rstw_busy", busy, 1'b0);
    check("rstw_mem_req", mem_if.req, 1'b0);
    check("rstw_mem_addr", mem_if.addr, 32'h0);
    set_port(0, 1'b1, 1'b0, 32'h0000_0400, 128'h0);
    set_port(1, 1'b1, 1'b0, 32'h0000_0500, 128'h0);
    step();
    @(negedge clk);
    check("rstw_conflict_addr", mem_if.addr, 32'h0000_0400);
    step();
    @(negedge clk);
    check("rstw_conflict_ready", {p0_if.ready, p1_if.ready}, 2'b10);
    step();
    set_port(0, 1'b0, 1'b0, 32'h0, 128'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 128'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
